// File: rtl/ptp_bridge_pkg.sv
// ptp_bridge_pkg: shared bridge types for segment info, classification results and egress scheduling
package ptp_bridge_pkg;
    typedef logic [3:0] EGR_PORT_T;
    typedef struct packed {
        logic      sop;
        logic      eop;
        EGR_PORT_T egr_port;
        logic [5:0] byte_cnt;
    } SEGMENT_INFO_S;
    typedef enum logic [1:0] {IDLE, FWD, DROP} SCHED_STATE_E;
    typedef struct packed {
        logic      drop;
        EGR_PORT_T egr_port;
    } CLS_RES_S;
endpackage

// File: rtl/parse_class_egr_sched_if.sv
// parse_class_egr_sched_if: egress AXI-stream bundle between scheduler (master) and bridge egress (slave)
interface parse_class_egr_sched_if import ptp_bridge_pkg::*; #(
    parameter int TDATA_WIDTH = 512,
    parameter int USERMETADATA_WIDTH = 1
) ();
    logic tvalid;
    logic tready;
    logic [TDATA_WIDTH-1:0] tdata;
    logic [USERMETADATA_WIDTH-1:0] tuser_usermetadata;
    SEGMENT_INFO_S tuser_segment_info;
    modport master(output tvalid, tdata, tuser_usermetadata, tuser_segment_info, input tready);
    modport slave(input tvalid, tdata, tuser_usermetadata, tuser_segment_info, output tready);
endinterface

// File: rtl/parse_class_res_fifo.sv
// parse_class_res_fifo: register-based FIFO for classification results with full/empty flags
module parse_class_res_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    logic do_wr, do_rd;
    assign full = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign do_rd = rd && !empty;
    // a pop frees the slot in the same cycle, so a write while full is still taken
    assign do_wr = wr && (!full || rd);
    assign rdata = mem[rp];
    always_ff @(posedge clk) begin
        if (do_wr) mem[wp] <= wdata;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            cnt <= '0;
        end else begin
            if (do_wr) wp <= wp + AW'(1);
            if (do_rd) rp <= rp + AW'(1);
            cnt <= cnt + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end
endmodule

// File: rtl/parse_class_egr_sched.sv
// parse_class_egr_sched: pairs in-order classification results with align FIFO packets, forwards or drops them
module parse_class_egr_sched import ptp_bridge_pkg::*; #(
    parameter int TDATA_WIDTH = 512,
    parameter int USERMETADATA_WIDTH = 1,
    parameter int RES_FIFO_DEPTH = 16,
    parameter int CNT_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cls_vld,
    input  logic                          cls_drop,
    input  EGR_PORT_T                     cls_egr_port,
    input  logic [TDATA_WIDTH-1:0]        aln_fifo_tdata,
    input  logic [USERMETADATA_WIDTH-1:0] aln_fifo_tuser_usermetadata,
    input  SEGMENT_INFO_S                 aln_fifo_tuser_segment_info,
    input  logic                          aln_fifo_empty,
    output logic                          aln_fifo_pop,
    parse_class_egr_sched_if.master       m,
    output logic [CNT_WIDTH-1:0]          pkt_fwd_cnt,
    output logic [CNT_WIDTH-1:0]          pkt_drop_cnt,
    output logic [CNT_WIDTH-1:0]          sop_err_cnt,
    output logic                          res_ovf
);
    SCHED_STATE_E state;
    EGR_PORT_T cur_port;
    CLS_RES_S res_head;
    SEGMENT_INFO_S out_seg;
    logic res_full, res_empty, res_pop, adv, beat_ok, fwd_pop, eop_pop;
    parse_class_res_fifo #(.DEPTH(RES_FIFO_DEPTH), .WIDTH($bits(CLS_RES_S))) u_res_fifo (
        .clk(clk),
        .rst(rst),
        .wr(cls_vld),
        .wdata({cls_drop, cls_egr_port}),
        .rd(res_pop),
        .rdata(res_head),
        .full(res_full),
        .empty(res_empty)
    );
    assign adv = !m.tvalid || m.tready;
    assign beat_ok = !aln_fifo_empty && !res_empty;
    assign res_pop = state == IDLE && beat_ok && aln_fifo_tuser_segment_info.sop;
    // IDLE only consumes stray non-sop beats; sop beats wait for a result
    assign aln_fifo_pop = !aln_fifo_empty && (state == IDLE ? !aln_fifo_tuser_segment_info.sop :
                                              state == FWD ? adv : 1'b1);
    assign fwd_pop = state == FWD && aln_fifo_pop;
    assign eop_pop = state != IDLE && aln_fifo_pop && aln_fifo_tuser_segment_info.eop;
    always_comb begin
        out_seg = aln_fifo_tuser_segment_info;
        out_seg.egr_port = cur_port;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cur_port <= '0;
            m.tvalid <= 1'b0;
            m.tdata <= '0;
            m.tuser_usermetadata <= '0;
            m.tuser_segment_info <= '0;
            pkt_fwd_cnt <= '0;
            pkt_drop_cnt <= '0;
            sop_err_cnt <= '0;
            res_ovf <= 1'b0;
        end else begin
            state <= res_pop ? (res_head.drop ? DROP : FWD) : eop_pop ? IDLE : state;
            if (res_pop) cur_port <= res_head.egr_port;
            if (cls_vld && res_full && !res_pop) res_ovf <= 1'b1;
            if (adv) m.tvalid <= fwd_pop;
            if (fwd_pop) begin
                m.tdata <= aln_fifo_tdata;
                m.tuser_usermetadata <= aln_fifo_tuser_usermetadata;
                m.tuser_segment_info <= out_seg;
            end
            if (eop_pop && state == FWD && !(&pkt_fwd_cnt)) pkt_fwd_cnt <= pkt_fwd_cnt + CNT_WIDTH'(1);
            if (eop_pop && state == DROP && !(&pkt_drop_cnt)) pkt_drop_cnt <= pkt_drop_cnt + CNT_WIDTH'(1);
            if (state == IDLE && aln_fifo_pop && !(&sop_err_cnt)) sop_err_cnt <= sop_err_cnt + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_parse_class_egr_sched.sv
// tb_parse_class_egr_sched: randomized scoreboard bench with a queue-based packet model
module tb_parse_class_egr_sched;
    import ptp_bridge_pkg::*;
    localparam int TW = 64, UW = 1, DEPTH = 16, CW = 32;
    logic clk = 0, rst = 1;
    always #5 clk = ~clk;
    logic cls_vld = 0, cls_drop = 0;
    EGR_PORT_T cls_egr_port = '0;
    logic [TW-1:0] aln_fifo_tdata;
    logic [UW-1:0] aln_fifo_tuser_usermetadata;
    SEGMENT_INFO_S aln_fifo_tuser_segment_info;
    logic aln_fifo_empty, aln_fifo_pop, res_ovf;
    logic [CW-1:0] pkt_fwd_cnt, pkt_drop_cnt, sop_err_cnt;
    parse_class_egr_sched_if #(.TDATA_WIDTH(TW), .USERMETADATA_WIDTH(UW)) m ();
    parse_class_egr_sched #(.TDATA_WIDTH(TW), .USERMETADATA_WIDTH(UW), .RES_FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .cls_vld(cls_vld), .cls_drop(cls_drop), .cls_egr_port(cls_egr_port),
        .aln_fifo_tdata(aln_fifo_tdata), .aln_fifo_tuser_usermetadata(aln_fifo_tuser_usermetadata),
        .aln_fifo_tuser_segment_info(aln_fifo_tuser_segment_info), .aln_fifo_empty(aln_fifo_empty),
        .aln_fifo_pop(aln_fifo_pop), .m(m), .pkt_fwd_cnt(pkt_fwd_cnt), .pkt_drop_cnt(pkt_drop_cnt),
        .sop_err_cnt(sop_err_cnt), .res_ovf(res_ovf)
    );
    typedef struct packed {
        logic [TW-1:0] d;
        logic [UW-1:0] u;
        SEGMENT_INFO_S s;
    } beat_t;
    beat_t aln_q[$], exp_q[$];
    CLS_RES_S res_q[$];
    int checks = 0, bad = 0, cyc = 0, n_pop = 0, n_tv = 0;
    int exp_fwd = 0, exp_drop = 0, exp_serr = 0;
    bit res_en = 1, rand_rdy = 0, chk_nopop = 0;

    function automatic beat_t mk_beat(bit sop, bit eop);
        beat_t b;
        b.d = {$urandom, $urandom};
        b.u = UW'($urandom);
        b.s.sop = sop;
        b.s.eop = eop;
        b.s.egr_port = 4'($urandom);
        b.s.byte_cnt = 6'($urandom);
        return b;
    endfunction

    task automatic drive_head();
        aln_fifo_empty = aln_q.size() == 0;
        {aln_fifo_tdata, aln_fifo_tuser_usermetadata, aln_fifo_tuser_segment_info} = aln_q.size() != 0 ? aln_q[0] : '0;
    endtask

    task automatic add_pkt(int n, bit drop, EGR_PORT_T port);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b = mk_beat(i == 0, i == n - 1);
            aln_q.push_back(b);
            b.s.egr_port = port;
            if (!drop) exp_q.push_back(b);
        end
        res_q.push_back(CLS_RES_S'({drop, port}));
        if (drop) exp_drop++;
        else exp_fwd++;
        drive_head();
    endtask

    task automatic add_orphan();
        aln_q.push_back(mk_beat(1'b0, 1'($urandom)));
        exp_serr++;
        drive_head();
    endtask

    task automatic push_res();
        CLS_RES_S r;
        if (res_q.size() != 0) begin
            r = res_q.pop_front();
            cls_vld = 1;
            cls_drop = r.drop;
            cls_egr_port = r.egr_port;
        end
    endtask

    task automatic clear_model();
        aln_q.delete();
        exp_q.delete();
        res_q.delete();
        exp_fwd = 0;
        exp_drop = 0;
        exp_serr = 0;
        cls_vld = 0;
        drive_head();
    endtask

    task automatic do_reset();
        rst = 1;
        cls_vld = 0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        clear_model();
    endtask

    // one clock: observe handshakes before the edge, then retire popped beats and feed the next result
    task automatic tick();
        logic p, held;
        beat_t got, snap, e;
        #1;
        p = aln_fifo_pop;
        if (p) n_pop++;
        if (m.tvalid) n_tv++;
        got = {m.tdata, m.tuser_usermetadata, m.tuser_segment_info};
        if (chk_nopop) begin
            checks++;
            if (p && m.tvalid && !m.tready) begin bad++; $display("FAIL pop_while_held cyc=%0d got=%b exp=0", cyc, p); end
        end
        if (m.tvalid && m.tready) begin
            checks++;
            if (exp_q.size() == 0) begin
                bad++; $display("FAIL unexpected_beat got=%h exp=none", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin bad++; $display("FAIL beat got=%h exp=%h", got, e); end
            end
        end
        held = m.tvalid && !m.tready;
        snap = got;
        @(posedge clk);
        @(negedge clk);
        cls_vld = 0;
        if (p && aln_q.size() != 0) void'(aln_q.pop_front());
        drive_head();
        if (held) begin
            checks++;
            got = {m.tdata, m.tuser_usermetadata, m.tuser_segment_info};
            if (!m.tvalid || got !== snap) begin bad++; $display("FAIL stall_stable got=%h v=%b exp=%h", got, m.tvalid, snap); end
        end
        cyc++;
        if (res_en) push_res();
        if (rand_rdy) m.tready = 1'($urandom_range(0, 1));
    endtask

    task automatic drain(int budget);
        int i = 0;
        while ((aln_q.size() != 0 || exp_q.size() != 0 || res_q.size() != 0 || m.tvalid) && i < budget) begin
            tick();
            i++;
        end
        checks++;
        if (i >= budget) begin bad++; $display("FAIL drain_timeout got=%0d exp=<%0d left=%0d", i, budget, exp_q.size()); end
    endtask

    task automatic chk_counters(string tag);
        checks += 3;
        if (pkt_fwd_cnt !== CW'(exp_fwd)) begin bad++; $display("FAIL %s fwd_cnt got=%0d exp=%0d", tag, pkt_fwd_cnt, exp_fwd); end
        if (pkt_drop_cnt !== CW'(exp_drop)) begin bad++; $display("FAIL %s drop_cnt got=%0d exp=%0d", tag, pkt_drop_cnt, exp_drop); end
        if (sop_err_cnt !== CW'(exp_serr)) begin bad++; $display("FAIL %s sop_err_cnt got=%0d exp=%0d", tag, sop_err_cnt, exp_serr); end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks += 3;
        if (m.tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b exp=0", m.tvalid); end
        if (res_ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", res_ovf); end
        if ({m.tdata, m.tuser_usermetadata, m.tuser_segment_info} !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", m.tdata); end
        chk_counters("reset");
    endtask

    task automatic test_fwd();
        bit pat[6] = '{0, 0, 1, 1, 1, 0};
        int p0 = n_pop;
        res_en = 0;
        add_pkt(3, 0, 4'd5);
        tick();
        tick();
        checks++;
        if (n_pop != p0) begin bad++; $display("FAIL fwd_wait_result pops got=%0d exp=0", n_pop - p0); end
        push_res();
        res_en = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (m.tvalid !== pat[i]) begin bad++; $display("FAIL fwd_latency step=%0d got=%b exp=%b", i, m.tvalid, pat[i]); end
        end
        drain(50);
        chk_counters("fwd");
    endtask

    task automatic test_drop();
        int p0 = n_pop, t0 = n_tv;
        add_pkt(3, 1, 4'd7);
        drain(50);
        checks += 2;
        if (n_pop - p0 != 3) begin bad++; $display("FAIL drop_pops got=%0d exp=3", n_pop - p0); end
        if (n_tv != t0) begin bad++; $display("FAIL drop_tvalid got=%0d exp=0", n_tv - t0); end
        chk_counters("drop");
        add_pkt(2, 0, 4'd4);
        drain(50);
        chk_counters("after_drop");
    endtask

    task automatic test_stall();
        chk_nopop = 1;
        add_pkt(4, 0, 4'd9);
        for (int i = 0; i < 24; i++) begin
            m.tready = (i % 4 == 0) || (i % 4 == 3);
            tick();
        end
        m.tready = 1;
        drain(50);
        chk_nopop = 0;
        chk_counters("stall");
    endtask

    task automatic test_back_to_back();
        add_pkt(1, 0, 4'd1);
        add_pkt(1, 0, 4'd2);
        drain(50);
        chk_counters("b2b");
    endtask

    task automatic test_sop_err();
        add_orphan();
        add_pkt(2, 0, 4'd3);
        drain(50);
        chk_counters("sop_err");
    endtask

    task automatic test_random();
        rand_rdy = 1;
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 8; k++) begin
                if ($urandom_range(0, 9) == 0) add_orphan();
                add_pkt($urandom_range(1, 5), $urandom_range(0, 3) == 0, 4'($urandom));
            end
            drain(1000);
            chk_counters("random");
        end
        rand_rdy = 0;
        m.tready = 1;
        checks++;
        if (res_ovf !== 1'b0) begin bad++; $display("FAIL random_ovf got=%b exp=0", res_ovf); end
    endtask

    task automatic test_ovf_reset();
        int p0;
        do_reset();
        for (int i = 0; i < 17; i++) res_q.push_back(CLS_RES_S'({1'b0, 4'(i)}));
        for (int i = 0; i < 17; i++) tick();
        checks++;
        if (res_ovf !== 1'b0) begin bad++; $display("FAIL ovf_at_full got=%b exp=0", res_ovf); end
        tick();
        checks++;
        if (res_ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", res_ovf); end
        repeat (5) tick();
        checks++;
        if (res_ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", res_ovf); end
        do_reset();
        #1;
        checks++;
        if (res_ovf !== 1'b0) begin bad++; $display("FAIL ovf_rst got=%b exp=0", res_ovf); end
        add_pkt(2, 0, 4'd6);
        drain(50);
        chk_counters("pre_mid_rst");
        add_pkt(5, 0, 4'd8);
        m.tready = 0;
        repeat (6) tick();
        checks++;
        if (m.tvalid !== 1'b1) begin bad++; $display("FAIL mid_fwd_held got=%b exp=1", m.tvalid); end
        rst = 1;
        @(posedge clk);
        #1;
        checks += 3;
        if (m.tvalid !== 1'b0) begin bad++; $display("FAIL mid_rst_tvalid got=%b exp=0", m.tvalid); end
        if (pkt_fwd_cnt !== '0) begin bad++; $display("FAIL mid_rst_cnt got=%0d exp=0", pkt_fwd_cnt); end
        if (res_ovf !== 1'b0) begin bad++; $display("FAIL mid_rst_ovf got=%b exp=0", res_ovf); end
        @(negedge clk);
        rst = 0;
        clear_model();
        m.tready = 1;
        res_en = 0;
        p0 = n_pop;
        add_pkt(1, 0, 4'd2);
        tick();
        tick();
        checks++;
        if (n_pop != p0) begin bad++; $display("FAIL mid_rst_idle pops got=%0d exp=0", n_pop - p0); end
        push_res();
        res_en = 1;
        drain(50);
        chk_counters("post_mid_rst");
    endtask

    initial begin
        m.tready = 1;
        drive_head();
        test_reset();
        test_fwd();
        test_drop();
        test_stall();
        test_back_to_back();
        test_sop_err();
        test_random();
        test_ovf_reset();
        $display("test done: total=%0d bad=%0d", checks, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
